// File: rtl/pow2_scale_pipe.sv
// -----------------------------------------------------------------------------
// pow2_scale_pipe
//
// Pipelined power-of-two scaler with four modes:
//   00 decode            Output = 1 << Exp
//   01 shift left        Output = Value << Exp   (Overflow if a 1 falls off)
//   10 logical right     Output = Value >> Exp
//   11 arithmetic right  Output = Value >>> Exp  (sign taken at input)
//
// Stage register 0 captures the request. Stage k (k = 0..EXP_WIDTH-1)
// conditionally shifts by 2**k using the exponent bit carried with the
// transaction, writing stage register k+1. The last register drives the
// outputs. Stalls are global: the pipe moves only when the output slot is
// empty or being consumed.
//
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   InValid / InReady   input handshake (InReady = advance)
//   Mode, Value, Exp    request
//   OutValid / OutReady output handshake
//   Output, Overflow    result, sticky lost-bit flag for left/decode
//   Busy                any stage holds a valid transaction
// -----------------------------------------------------------------------------
module pow2_scale_pipe #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 5
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [1:0]           Mode,
    input  logic [WIDTH-1:0]     Value,
    input  logic [EXP_WIDTH-1:0] Exp,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [WIDTH-1:0]     Output,
    output logic                 Overflow,
    output logic                 Busy
);

    localparam int STAGES = EXP_WIDTH;

    typedef struct packed {
        logic                 vld;
        logic [1:0]           mode;
        logic [EXP_WIDTH-1:0] exp;
        logic                 sign;
        logic                 ovf;
        logic [WIDTH-1:0]     data;
    } stage_t;

    stage_t stage_q [0:STAGES];
    stage_t stage_d [0:STAGES];

    logic advance;

    assign advance = !stage_q[STAGES].vld || OutReady;
    assign InReady = advance;

    always_comb begin
        stage_t      cur;
        stage_t      nxt;
        logic        big;
        int unsigned amt;

        // Bubbles enter as all-zero so idle stages never carry stale data.
        stage_d[0] = '0;
        if (InValid) begin
            stage_d[0].vld  = 1'b1;
            stage_d[0].mode = Mode;
            stage_d[0].exp  = Exp;
            stage_d[0].sign = Value[WIDTH-1];
            stage_d[0].data = (Mode == 2'b00) ? WIDTH'(1) : Value;
        end

        for (int k = 0; k < STAGES; k++) begin
            cur = stage_q[k];
            nxt = cur;
            amt = 32'd1 << k;
            // Shift distances at or beyond WIDTH saturate instead of wrapping.
            big = (k >= 31) || (amt >= 32'(WIDTH));
            if (cur.exp[k]) begin
                if (!cur.mode[1]) begin
                    if (big) begin
                        nxt.data = '0;
                        nxt.ovf  = cur.ovf | (|cur.data);
                    end else begin
                        nxt.data = cur.data << amt;
                        nxt.ovf  = cur.ovf | (|(cur.data >> (32'(WIDTH) - amt)));
                    end
                end else if (!cur.mode[0]) begin
                    nxt.data = big ? '0 : (cur.data >> amt);
                end else begin
                    nxt.data = big ? {WIDTH{cur.sign}}
                                   : WIDTH'({{WIDTH{cur.sign}}, cur.data} >> amt);
                end
            end
            stage_d[k+1] = nxt;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k <= STAGES; k++) stage_q[k] <= '0;
        end else if (advance) begin
            for (int k = 0; k <= STAGES; k++) stage_q[k] <= stage_d[k];
        end
    end

    assign OutValid = stage_q[STAGES].vld;
    assign Output   = stage_q[STAGES].data;
    assign Overflow = stage_q[STAGES].ovf;

    always_comb begin
        Busy = 1'b0;
        for (int k = 0; k <= STAGES; k++) Busy = Busy | stage_q[k].vld;
    end

    // Control fields are dead once the last shift has been applied.
    logic unused_tail;
    assign unused_tail = ^{stage_q[STAGES].mode, stage_q[STAGES].exp, stage_q[STAGES].sign};

endmodule
